// File: rtl/mem_arbiter.sv
// Memory port arbiter: one write requester with priority over N_RD round-robin
// read channels, sharing a single byte-wide RAM port with pause and rollback.
module mem_arbiter #(
    parameter int N_RD = 2,
    parameter int MAX_LEN = 16,
    parameter logic [N_RD-1:0] RB_MASK = N_RD'(1),
    localparam int LEN_W = $clog2(MAX_LEN) + 1,
    localparam int CH_W = (N_RD > 1) ? $clog2(N_RD) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     rb,
    input  logic [N_RD-1:0]          rd_req,
    input  logic [32*N_RD-1:0]       rd_addr,
    input  logic [LEN_W*N_RD-1:0]    rd_len,
    output logic [N_RD-1:0]          rd_done,
    output logic [8*MAX_LEN-1:0]     rd_data,
    input  logic                     wr_req,
    input  logic [31:0]              wr_addr,
    input  logic [31:0]              wr_data,
    input  logic [2:0]               wr_len,
    output logic                     wr_done,
    output logic                     ram_rw_sel,
    output logic [31:0]              ram_addr,
    output logic [7:0]               ram_wr_byte,
    input  logic [7:0]               ram_rd_byte,
    input  logic                     io_buffer_full
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t               state_q, state_d;
    logic [CH_W-1:0]      ptr_q, ptr_d, ch_q, ch_d;
    logic [31:0]          ram_addr_q, ram_addr_d, prev_addr_q, prev_addr_d;
    logic [7:0]           ram_wr_byte_q, ram_wr_byte_d;
    logic [LEN_W-1:0]     len_q, len_d, iss_q, iss_d, cap_q, cap_d;
    logic                 issuing_q, issuing_d;
    logic [8*MAX_LEN-1:0] buf_q, buf_d, rd_data_q, rd_data_d;
    logic [N_RD-1:0]      rd_done_q, rd_done_d;
    logic                 wr_done_q, wr_done_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [2:0]           wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic                 io_hold_q, io_hold_d;

    logic [31:0]          ch_addr [N_RD];
    logic [LEN_W-1:0]     ch_len [N_RD];

    genvar gi;
    generate
        for (gi = 0; gi < N_RD; gi++) begin : g_ch
            logic [LEN_W-1:0] raw_len;
            assign raw_len = rd_len[gi*LEN_W +: LEN_W];
            assign ch_addr[gi] = rd_addr[gi*32 +: 32];
            assign ch_len[gi] = (raw_len == '0) ? LEN_W'(1) :
                                (raw_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : raw_len;
        end
    endgenerate

    // Round-robin search; a channel completing this cycle sits out.
    logic [N_RD-1:0] elig;
    logic            gnt_found;
    logic [CH_W-1:0] gnt_ch;
    int              idx;

    always_comb begin
        elig      = rd_req & ~rd_done_q & (rb ? ~RB_MASK : {N_RD{1'b1}});
        gnt_found = 1'b0;
        gnt_ch    = '0;
        idx       = 0;
        for (int i = 1; i <= N_RD; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_RD) idx = idx - N_RD;
            if (!gnt_found && elig[idx[CH_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_ch    = idx[CH_W-1:0];
            end
        end
    end

    logic             wr_blocked;
    logic [LEN_W-1:0] cap_lim;

    assign wr_blocked = io_hold_q && io_buffer_full;
    assign cap_lim    = issuing_q ? iss_q : len_q;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        ch_d          = ch_q;
        ram_addr_d    = ram_addr_q;
        prev_addr_d   = rdy ? ram_addr_q : prev_addr_q;
        ram_wr_byte_d = ram_wr_byte_q;
        len_d         = len_q;
        iss_d         = iss_q;
        cap_d         = cap_q;
        issuing_d     = issuing_q;
        buf_d         = buf_q;
        rd_data_d     = rd_data_q;
        rd_done_d     = '0;
        wr_done_d     = 1'b0;
        wdata_d       = wdata_q;
        wlen_d        = wlen_q;
        wcnt_d        = wcnt_q;
        io_hold_d     = io_hold_q;

        case (state_q)
            IDLE: begin
                if (rdy) begin
                    if (wr_req) begin
                        state_d       = WR;
                        ram_addr_d    = wr_addr;
                        ram_wr_byte_d = wr_data[7:0];
                        wdata_d       = wr_data;
                        wlen_d        = (wr_len == 3'd1 || wr_len == 3'd2 || wr_len == 3'd4) ? wr_len : 3'd4;
                        wcnt_d        = 3'd0;
                        io_hold_d     = (wr_addr[17:16] == 2'b11);
                    end else if (gnt_found) begin
                        state_d    = RD;
                        ch_d       = gnt_ch;
                        ptr_d      = gnt_ch;
                        ram_addr_d = ch_addr[gnt_ch];
                        len_d      = ch_len[gnt_ch];
                        iss_d      = '0;
                        cap_d      = '0;
                        issuing_d  = 1'b1;
                        buf_d      = '0;
                    end
                end
            end
            RD: begin
                if (rdy) begin
                    if (rb && RB_MASK[ch_q]) begin
                        state_d    = IDLE;
                        ram_addr_d = '0;
                    end else begin
                        if (issuing_q) begin
                            if (iss_q + LEN_W'(1) < len_q) begin
                                iss_d      = iss_q + LEN_W'(1);
                                ram_addr_d = ram_addr_q + 32'd1;
                            end else begin
                                issuing_d = 1'b0;
                            end
                        end
                        // RAM data lags the address by one cycle, so capture trails issue.
                        if (cap_q < cap_lim) begin
                            buf_d[8*int'(cap_q) +: 8] = ram_rd_byte;
                            cap_d = cap_q + LEN_W'(1);
                            if (cap_q + LEN_W'(1) == len_q) begin
                                state_d          = IDLE;
                                rd_done_d[ch_q]  = 1'b1;
                                rd_data_d        = buf_d;
                                ram_addr_d       = '0;
                            end
                        end
                    end
                end
            end
            WR: begin
                if (rdy && !wr_blocked) begin
                    if (wcnt_q + 3'd1 < wlen_q) begin
                        wcnt_d        = wcnt_q + 3'd1;
                        wdata_d       = wdata_q >> 8;
                        ram_wr_byte_d = wdata_q[15:8];
                        ram_addr_d    = ram_addr_q + 32'd1;
                    end else begin
                        state_d       = IDLE;
                        wr_done_d     = 1'b1;
                        ram_addr_d    = '0;
                        ram_wr_byte_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= CH_W'(N_RD - 1);
            ch_q          <= '0;
            ram_addr_q    <= '0;
            prev_addr_q   <= '0;
            ram_wr_byte_q <= '0;
            len_q         <= '0;
            iss_q         <= '0;
            cap_q         <= '0;
            issuing_q     <= 1'b0;
            buf_q         <= '0;
            rd_data_q     <= '0;
            rd_done_q     <= '0;
            wr_done_q     <= 1'b0;
            wdata_q       <= '0;
            wlen_q        <= '0;
            wcnt_q        <= '0;
            io_hold_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            ch_q          <= ch_d;
            ram_addr_q    <= ram_addr_d;
            prev_addr_q   <= prev_addr_d;
            ram_wr_byte_q <= ram_wr_byte_d;
            len_q         <= len_d;
            iss_q         <= iss_d;
            cap_q         <= cap_d;
            issuing_q     <= issuing_d;
            buf_q         <= buf_d;
            rd_data_q     <= rd_data_d;
            rd_done_q     <= rd_done_d;
            wr_done_q     <= wr_done_d;
            wdata_q       <= wdata_d;
            wlen_q        <= wlen_d;
            wcnt_q        <= wcnt_d;
            io_hold_q     <= io_hold_d;
        end
    end

    // While paused in a read, keep presenting the address whose data is still owed.
    assign ram_addr    = (state_q == RD && !rdy) ? prev_addr_q : ram_addr_q;
    assign ram_rw_sel  = (state_q == WR) && rdy && !wr_blocked;
    assign ram_wr_byte = ram_wr_byte_q;
    assign rd_done     = rd_done_q;
    assign wr_done     = wr_done_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expectations,
// a negedge monitor pops and compares them as the DUT produces events.
module tb_mem_arbiter;

    localparam int LW = 5;

    logic         clk = 1'b0;
    logic         rst, rdy, rb;
    logic [1:0]   rd_req;
    logic [63:0]  rd_addr;
    logic [9:0]   rd_len;
    logic [1:0]   rd_done;
    logic [127:0] rd_data;
    logic         wr_req;
    logic [31:0]  wr_addr, wr_data;
    logic [2:0]   wr_len;
    logic         wr_done;
    logic         ram_rw_sel;
    logic [31:0]  ram_addr;
    logic [7:0]   ram_wr_byte, ram_rd_byte;
    logic         io_buffer_full;

    mem_arbiter #(.N_RD(2), .MAX_LEN(16)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rb(rb),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
        .rd_done(rd_done), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_len(wr_len),
        .wr_done(wr_done), .ram_rw_sel(ram_rw_sel), .ram_addr(ram_addr),
        .ram_wr_byte(ram_wr_byte), .ram_rd_byte(ram_rd_byte),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ram_f(input logic [31:0] a);
        logic [31:0] t;
        if (a >= 32'h100 && a <= 32'h103) begin
            t = 32'h11 * (a - 32'hFF);
            return t[7:0];
        end
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    always @(posedge clk) ram_rd_byte <= ram_f(ram_addr);

    function automatic logic [127:0] exp_rd(input logic [31:0] a, input int l);
        logic [127:0] d;
        d = '0;
        for (int k = 0; k < l; k++) d[8*k +: 8] = ram_f(a + 32'(k));
        return d;
    endfunction

    typedef struct { int cyc; logic [1:0] ch; logic [127:0] data; } rd_e_t;
    typedef struct { int cyc; logic [31:0] addr; logic [7:0] b; } wb_e_t;
    typedef struct { int cyc; logic [31:0] addr; logic zero; logic dchk; logic [127:0] data; } pr_e_t;

    rd_e_t rd_q[$];
    int    wr_q[$];
    wb_e_t wb_q[$];
    pr_e_t pr_q[$];

    int n_vec = 0;
    int n_bad = 0;

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
        end
    endfunction

    task automatic probe(input int c, input logic [31:0] a, input logic z,
                         input logic dc, input logic [127:0] d);
        pr_e_t p;
        p.cyc = c; p.addr = a; p.zero = z; p.dchk = dc; p.data = d;
        pr_q.push_back(p);
    endtask

    task automatic exp_read(input int c, input logic [1:0] ch, input logic [127:0] d);
        rd_e_t e;
        e.cyc = c; e.ch = ch; e.data = d;
        rd_q.push_back(e);
    endtask

    task automatic exp_wbyte(input int c, input logic [31:0] a, input logic [7:0] b);
        wb_e_t e;
        e.cyc = c; e.addr = a; e.b = b;
        wb_q.push_back(e);
    endtask

    // Monitor
    pr_e_t m_p;
    rd_e_t m_r;
    wb_e_t m_w;
    int    m_c;
    always @(negedge clk) begin
        while (pr_q.size() > 0 && pr_q[0].cyc <= cyc) begin
            m_p = pr_q.pop_front();
            chk("probe_cyc", 128'(cyc), 128'(m_p.cyc));
            chk("probe_addr", 128'(ram_addr), 128'(m_p.addr));
            chk("probe_rw", 128'(ram_rw_sel), 128'(0));
            if (m_p.zero) begin
                chk("rst_wbyte", 128'(ram_wr_byte), 128'(0));
                chk("rst_rddata", rd_data, 128'(0));
                chk("rst_done", 128'({rd_done, wr_done}), 128'(0));
            end
            if (m_p.dchk) chk("rd_data_hold", rd_data, m_p.data);
        end
        if (rd_done != 2'b00) begin
            if (rd_q.size() == 0) chk("rd_done_unexp", 128'(rd_done), 128'(0));
            else begin
                m_r = rd_q.pop_front();
                $display("read done ch_mask=%b cycle %0d data=%h", rd_done, cyc, rd_data);
                chk("rd_ch", 128'(rd_done), 128'(m_r.ch));
                chk("rd_cyc", 128'(cyc), 128'(m_r.cyc));
                chk("rd_data", rd_data, m_r.data);
            end
        end
        if (wr_done) begin
            if (wr_q.size() == 0) chk("wr_done_unexp", 128'(wr_done), 128'(0));
            else begin
                m_c = wr_q.pop_front();
                $display("write done cycle %0d", cyc);
                chk("wr_done_cyc", 128'(cyc), 128'(m_c));
            end
        end
        if (ram_rw_sel) begin
            if (wb_q.size() == 0) chk("wbyte_unexp", 128'(ram_rw_sel), 128'(0));
            else begin
                m_w = wb_q.pop_front();
                $display("ram write addr=%h byte=%h cycle %0d", ram_addr, ram_wr_byte, cyc);
                chk("wb_addr", 128'(ram_addr), 128'(m_w.addr));
                chk("wb_byte", 128'(ram_wr_byte), 128'(m_w.b));
                chk("wb_cyc", 128'(cyc), 128'(m_w.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    int k;

    initial begin
        rst = 1'b1; rdy = 1'b1; rb = 1'b0;
        rd_req = '0; rd_addr = '0; rd_len = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_len = '0;
        io_buffer_full = 1'b0;
        tick(); tick();
        probe(cyc, 32'h0, 1'b1, 1'b0, '0);
        tick();
        rst = 1'b0;
        tick();

        // Write beats both reads; then ch0, ch1, ch0 in round-robin order.
        k = cyc;
        wr_req = 1'b1; wr_addr = 32'h2000; wr_data = 32'hA1B2C3D4; wr_len = 3'd2;
        rd_req = 2'b11;
        rd_addr = {32'h300, 32'h200}; rd_len = {5'd3, 5'd2};
        exp_wbyte(k + 1, 32'h2000, 8'hD4);
        exp_wbyte(k + 2, 32'h2001, 8'hC3);
        wr_q.push_back(k + 3);
        probe(k + 3, 32'h0, 1'b0, 1'b0, '0);
        exp_read(k + 7, 2'b01, exp_rd(32'h200, 2));
        exp_read(k + 12, 2'b10, exp_rd(32'h300, 3));
        exp_read(k + 16, 2'b01, exp_rd(32'h200, 2));
        goto(k + 1); wr_req = 1'b0;
        goto(k + 13); rd_req = 2'b00;
        goto(k + 18);

        // Basic 4-byte read.
        k = cyc;
        rd_req = 2'b01; rd_addr[31:0] = 32'h100; rd_len[4:0] = 5'd4;
        for (int i = 0; i < 4; i++) probe(k + 1 + i, 32'h100 + 32'(i), 1'b0, 1'b0, '0);
        exp_read(k + 6, 2'b01, 128'h44332211);
        probe(k + 6, 32'h0, 1'b0, 1'b0, '0);
        goto(k + 1); rd_req = 2'b00;
        goto(k + 8);

        // I/O-region write held off by io_buffer_full.
        k = cyc;
        wr_req = 1'b1; wr_addr = 32'h0003_0000; wr_data = 32'h41; wr_len = 3'd1;
        io_buffer_full = 1'b1;
        for (int i = 1; i <= 5; i++) probe(k + i, 32'h0003_0000, 1'b0, 1'b0, '0);
        exp_wbyte(k + 6, 32'h0003_0000, 8'h41);
        wr_q.push_back(k + 7);
        goto(k + 1); wr_req = 1'b0;
        goto(k + 6); io_buffer_full = 1'b0;
        goto(k + 9);

        // Rollback on masked ch0: no done, rd_data untouched.
        k = cyc;
        rd_req = 2'b01; rd_addr[31:0] = 32'h400; rd_len[4:0] = 5'd8;
        probe(k + 3, 32'h0, 1'b0, 1'b1, 128'h44332211);
        probe(k + 12, 32'h0, 1'b0, 1'b1, 128'h44332211);
        goto(k + 1); rd_req = 2'b00;
        goto(k + 2); rb = 1'b1;
        goto(k + 3); rb = 1'b0;
        goto(k + 13);

        // Masked request ignored while rb is high in IDLE.
        k = cyc;
        rd_req = 2'b01; rd_addr[31:0] = 32'h800; rd_len[4:0] = 5'd1; rb = 1'b1;
        probe(k + 1, 32'h0, 1'b0, 1'b0, '0);
        probe(k + 2, 32'h800, 1'b0, 1'b0, '0);
        exp_read(k + 4, 2'b01, exp_rd(32'h800, 1));
        goto(k + 1); rb = 1'b0;
        goto(k + 2); rd_req = 2'b00;
        goto(k + 6);

        // Rollback does not affect unmasked ch1.
        k = cyc;
        rd_req = 2'b10; rd_addr[63:32] = 32'h500; rd_len[9:5] = 5'd8;
        exp_read(k + 10, 2'b10, exp_rd(32'h500, 8));
        goto(k + 1); rd_req = 2'b00;
        goto(k + 2); rb = 1'b1;
        goto(k + 3); rb = 1'b0;
        goto(k + 12);

        // Length 0 acts as 1.
        k = cyc;
        rd_req = 2'b01; rd_addr[31:0] = 32'hFFFF_FFFF; rd_len[4:0] = 5'd0;
        exp_read(k + 3, 2'b01, exp_rd(32'hFFFF_FFFF, 1));
        goto(k + 1); rd_req = 2'b00;
        goto(k + 5);

        // Length clamped to 16, address wraps past 2^32.
        k = cyc;
        rd_req = 2'b01; rd_addr[31:0] = 32'hFFFF_FFF8; rd_len[4:0] = 5'd31;
        probe(k + 1, 32'hFFFF_FFF8, 1'b0, 1'b0, '0);
        probe(k + 10, 32'h1, 1'b0, 1'b0, '0);
        exp_read(k + 18, 2'b01, exp_rd(32'hFFFF_FFF8, 16));
        goto(k + 1); rd_req = 2'b00;
        goto(k + 20);

        // wr_len 5 behaves as 4, wrapping address.
        k = cyc;
        wr_req = 1'b1; wr_addr = 32'hFFFF_FFFE; wr_data = 32'hCAFEBABE; wr_len = 3'd5;
        exp_wbyte(k + 1, 32'hFFFF_FFFE, 8'hBE);
        exp_wbyte(k + 2, 32'hFFFF_FFFF, 8'hBA);
        exp_wbyte(k + 3, 32'h0, 8'hFE);
        exp_wbyte(k + 4, 32'h1, 8'hCA);
        wr_q.push_back(k + 5);
        goto(k + 1); wr_req = 1'b0;
        goto(k + 7);

        // Pause for 3 cycles mid-read: +3 latency, same bytes.
        k = cyc;
        rd_req = 2'b01; rd_addr[31:0] = 32'h600; rd_len[4:0] = 5'd4;
        probe(k + 1, 32'h600, 1'b0, 1'b0, '0);
        probe(k + 2, 32'h600, 1'b0, 1'b0, '0);
        probe(k + 4, 32'h600, 1'b0, 1'b0, '0);
        probe(k + 5, 32'h601, 1'b0, 1'b0, '0);
        probe(k + 7, 32'h603, 1'b0, 1'b0, '0);
        exp_read(k + 9, 2'b01, exp_rd(32'h600, 4));
        goto(k + 1); rd_req = 2'b00;
        goto(k + 2); rdy = 1'b0;
        goto(k + 5); rdy = 1'b1;
        goto(k + 11);

        // Reset in the middle of a 4-byte write.
        k = cyc;
        wr_req = 1'b1; wr_addr = 32'h700; wr_data = 32'h11223344; wr_len = 3'd4;
        exp_wbyte(k + 1, 32'h700, 8'h44);
        exp_wbyte(k + 2, 32'h701, 8'h33);
        probe(k + 3, 32'h0, 1'b1, 1'b0, '0);
        probe(k + 6, 32'h0, 1'b1, 1'b0, '0);
        goto(k + 1); wr_req = 1'b0;
        goto(k + 3); rst = 1'b1;
        goto(k + 5); rst = 1'b0;
        goto(k + 9);

        chk("left_rd", 128'(rd_q.size()), 128'(0));
        chk("left_wr", 128'(wr_q.size()), 128'(0));
        chk("left_wb", 128'(wb_q.size()), 128'(0));
        chk("left_probe", 128'(pr_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter N_RD, default 2: number of read channels (1..8).
REQ-002 SHALL have parameter MAX_LEN, default 16: max bytes per read burst (power of 2, 4..64); LEN_W = clog2(MAX_LEN)+1.
REQ-003 SHALL have parameter RB_MASK, default {N_RD{1'b0}} with bit 0 set: read channels aborted by rollback.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk in 1, rising-edge system clock; rst in 1, asynchronous active-high reset.
REQ-005 SHALL have ports rdy in 1 (pause when low) and rb in 1 (rollback).
REQ-006 SHALL have ports rd_req in N_RD, rd_addr in 32*N_RD, rd_len in LEN_W*N_RD, rd_done out N_RD and rd_data out 8*MAX_LEN; rd_data is shared by all channels, byte k at [8k+7:8k].
REQ-007 SHALL have ports wr_req in 1, wr_addr in 32, wr_data in 32, wr_len in 3 (1/2/4) and wr_done out 1.
REQ-008 SHALL have ports ram_rw_sel out 1 (1=write), ram_addr out 32, ram_wr_byte out 8, ram_rd_byte in 8 and io_buffer_full in 1.

Function
REQ-009 SHALL implement FSM states IDLE, RD, WR; only IDLE arbitrates.
REQ-010 SHALL give wr_req priority over every rd_req in IDLE.
REQ-011 SHALL arbitrate reads round-robin: search starts at last granted channel + 1 (mod N_RD); pointer resets to N_RD-1, so channel 0 wins first.
REQ-012 SHALL latch addr, len and channel id at the grant edge; later changes to the request inputs are ignored until done.
REQ-013 SHALL, for a read granted at edge t: issue addresses addr..addr+L-1 (rw=0) in cycles t+1..t+L, capture ram_rd_byte one cycle after each issue into byte k, and pulse rd_done[ch] in cycle t+L+2 (latency L+2).
REQ-014 SHALL treat rd_len=0 as 1 and clamp rd_len>MAX_LEN to MAX_LEN.
REQ-015 SHALL drive rd_data bytes >= L as 0; rd_data holds until the next read completes.
REQ-016 SHALL, for a write granted at t: drive bytes wr_data[7:0] first (little-endian) at wr_addr+k, rw=1, in cycles t+1..t+len, and pulse wr_done in cycle t+len+1.
REQ-017 SHALL treat wr_len values other than 1/2/4 as 4.
REQ-018 SHALL hold the current write byte with rw=0 (no advance) while wr_addr[17:16]==2'b11 and io_buffer_full=1, and resume once it clears.
REQ-019 SHALL be back in IDLE in every done-pulse cycle; the channel whose done is high SHALL be excluded from that cycle's arbitration.
REQ-020 SHALL, while rdy=0, freeze all state and pointers and force ram_rw_sel=0; bytes whose capture cycle had rdy=0 SHALL be re-issued after resume.
REQ-021 SHALL, when rb=1 during RD on a channel with its RB_MASK bit set, enter IDLE next cycle with no done pulse, and leave rd_data unchanged.
REQ-022 SHALL not abort WR on rb, and SHALL not abort RD on unmasked channels.
REQ-023 SHALL ignore rd_req of masked channels in an IDLE cycle with rb=1.
REQ-024 SHALL drive ram_addr=0, ram_rw_sel=0 and ram_wr_byte=0 in IDLE.
REQ-025 SHALL compute address increments modulo 2^32.

Reset
REQ-026 SHALL, on rst=1 (asynchronous), set state IDLE, RR pointer N_RD-1, rd_done=0, wr_done=0, rd_data=0, ram_rw_sel=0, ram_addr=0 and ram_wr_byte=0.
REQ-027 SHALL abort a transfer in progress at reset with no done pulse; the first grant occurs no earlier than the first edge after rst falls.

Verification
REQ-028 Read ch0, addr 0x100, len 4, RAM bytes 11,22,33,44 -> addresses 0x100..0x103 in cycles t+1..t+4; rd_done[0] at t+6; rd_data[31:0]=0x44332211, upper bytes 0.
REQ-029 wr_req and rd_req[0], rd_req[1] all high in same IDLE cycle -> write first; then ch0 read, then ch1 read; rr order ch0 -> ch1 -> ch0 with both held.
REQ-030 Write 0x30000, data 0x41, len 1, io_buffer_full high 5 cycles -> rw=0 for those 5 cycles, then one write of 0x41; wr_done 1 cycle later.
REQ-031 rb pulsed at cycle t+2 of a len-8 read on ch0 (masked) -> IDLE at t+3, no rd_done[0]; same stimulus on ch1 (unmasked) completes normally.
REQ-032 rdy low 3 cycles mid len-4 read, and rst asserted mid-write -> read completes with correct bytes and latency +3; reset forces all outputs to their reset values immediately, with no wr_done.
